// File: rtl/median_window_feeder_if.sv
// Pixel-in / window-out handshake bundle of the median window feeder.
// The slave side is the feeder; the master side is the pixel source plus the median stage.
interface median_window_feeder_if #(
    parameter int NBITS = 8
);
    logic [NBITS-1:0] DI;
    logic             DVI;
    logic             SOF;
    logic             RDY;
    logic             BUSY;
    logic [NBITS-1:0] DO;
    logic             DSO;

    modport master (
        output DI, DVI, SOF, BUSY,
        input  RDY, DO, DSO
    );

    modport slave (
        input  DI, DVI, SOF, BUSY,
        output RDY, DO, DSO
    );
endinterface

// File: rtl/median_window_feeder.sv
// Builds a 3x3 neighbourhood around each interior raster pixel from two line buffers and
// serialises it as a 9-pixel burst for the systolic median element, stalling the input meanwhile.
module median_window_feeder #(
    parameter int NBITS = 8,
    parameter int WIDTH = 640
) (
    input  logic                   CLK,
    input  logic                   RST,
    median_window_feeder_if.slave  bus
);

    localparam int CW = (WIDTH > 4) ? $clog2(WIDTH) : 2;

    typedef enum logic [1:0] {
        S_ACCEPT,
        S_HOLD,
        S_EMIT
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]    col;
    logic [CW-1:0]    col_pos;
    logic [CW-1:0]    col_next;
    logic [1:0]       row;
    logic [1:0]       row_pos;
    logic [1:0]       row_next;
    logic             col_wrap;

    logic [NBITS-1:0] line1 [WIDTH];
    logic [NBITS-1:0] line2 [WIDTH];
    logic [NBITS-1:0] win       [9];
    logic [NBITS-1:0] win_shift [9];

    logic [3:0]       k;
    logic [3:0]       k_next;
    logic [3:0]       k_inc;
    logic [NBITS-1:0] do_q;
    logic [NBITS-1:0] do_next;
    logic             rdy_q;
    logic             dso_q;

    logic             accept;
    logic             win_valid;

    assign bus.RDY = rdy_q;
    assign bus.DSO = dso_q;
    assign bus.DO  = do_q;

    assign accept = bus.DVI && rdy_q && !RST;

    // SOF overrides the running position so the pixel itself lands at (0,0).
    always_comb begin
        col_pos  = bus.SOF ? '0 : col;
        row_pos  = bus.SOF ? '0 : row;
        col_wrap = (col_pos == CW'(WIDTH - 1));
        col_next = col_wrap ? '0 : col_pos + CW'(1);
        row_next = (col_wrap && row_pos != 2'd2) ? row_pos + 2'd1 : row_pos;
    end

    assign win_valid = (row_pos == 2'd2) && (col_pos >= CW'(2));

    // Window is row-major, row 0 oldest; the right column comes from the buffers before their write.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_shift[3*r]     = win[3*r + 1];
            win_shift[3*r + 1] = win[3*r + 2];
        end
        win_shift[2] = line2[col_pos];
        win_shift[5] = line1[col_pos];
        win_shift[8] = bus.DI;
    end

    assign k_inc = k + 4'd1;

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_next = state;
        k_next     = k;
        do_next    = do_q;
        unique case (state)
            S_ACCEPT: begin
                if (accept && win_valid) begin
                    if (bus.BUSY) begin
                        state_next = S_HOLD;
                    end else begin
                        state_next = S_EMIT;
                        k_next     = 4'd0;
                        do_next    = win_shift[0];
                    end
                end
            end
            S_HOLD: begin
                if (!bus.BUSY) begin
                    state_next = S_EMIT;
                    k_next     = 4'd0;
                    do_next    = win[0];
                end
            end
            S_EMIT: begin
                if (k == 4'd8) begin
                    state_next = S_ACCEPT;
                    k_next     = 4'd0;
                end else begin
                    k_next  = k_inc;
                    do_next = win[k_inc];
                end
            end
            default: begin
                state_next = S_ACCEPT;
                k_next     = 4'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_ACCEPT;
            k     <= 4'd0;
            col   <= '0;
            row   <= 2'd0;
            rdy_q <= 1'b1;
            dso_q <= 1'b0;
            do_q  <= '0;
        end else begin
            state <= state_next;
            k     <= k_next;
            rdy_q <= (state_next == S_ACCEPT);
            dso_q <= (state_next == S_EMIT);
            do_q  <= do_next;
            if (accept) begin
                col <= col_next;
                row <= row_next;
            end
        end
    end

    // NOTE: line buffers and window carry no reset; geometry guarantees they are refilled before use.
    always_ff @(posedge CLK) begin
        if (accept) begin
            line2[col_pos] <= line1[col_pos];
            line1[col_pos] <= bus.DI;
            for (int i = 0; i < 9; i++) begin
                win[i] <= win_shift[i];
            end
        end
    end

endmodule

// File: tb/tb_median_window_feeder.sv
// Self-checking bench for median_window_feeder: image-level reference model compared every cycle,
// plus literal burst expectations from the directed scenarios.
module tb_median_window_feeder;

    localparam int NBITS = 8;
    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    median_window_feeder_if #(.NBITS(NBITS)) bus ();

    median_window_feeder #(.NBITS(NBITS), .WIDTH(WIDTH)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: keeps the last three image lines since the last SOF/reset and the
    // expected outstanding burst; outputs are derived from those.
    logic [7:0] img [3][WIDTH];
    logic [7:0] win_exp [9];
    int  m_line    = 0;
    int  m_col     = 0;
    int  remaining = 0;
    bit  pending   = 1'b0;
    bit  m_rdy     = 1'b1;
    bit  check_en  = 1'b0;

    task automatic model_step();
        if (rst) begin
            m_rdy     = 1'b1;
            pending   = 1'b0;
            remaining = 0;
            m_line    = 0;
            m_col     = 0;
        end else if (remaining > 0) begin
            remaining--;
            if (remaining == 0) m_rdy = 1'b1;
        end else if (pending) begin
            if (!bus.BUSY) begin
                pending   = 1'b0;
                remaining = 9;
            end
        end else if (m_rdy && bus.DVI) begin
            if (bus.SOF) begin
                m_line = 0;
                m_col  = 0;
            end
            img[m_line % 3][m_col] = bus.DI;
            if (m_line >= 2 && m_col >= 2) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        win_exp[i*3 + j] = img[(m_line - 2 + i) % 3][m_col - 2 + j];
                m_rdy = 1'b0;
                if (bus.BUSY) pending = 1'b1;
                else          remaining = 9;
            end
            m_col++;
            if (m_col == WIDTH) begin
                m_col = 0;
                m_line++;
            end
        end
    endtask

    always @(posedge clk) model_step();

    logic [7:0] got_q [$];

    always @(negedge clk) begin
        if (check_en) begin
            check("rdy", {71'd0, bus.RDY}, {71'd0, m_rdy});
            check("dso", {71'd0, bus.DSO}, {71'd0, remaining > 0});
            if (remaining > 0)
                check("do", {64'd0, bus.DO}, {64'd0, win_exp[9 - remaining]});
            if (bus.DSO) got_q.push_back(bus.DO);
        end
    end

    function automatic logic [71:0] burst_vec(input int b);
        logic [71:0] v = '0;
        for (int i = 0; i < 9; i++)
            v = {v[63:0], (b*9 + i < got_q.size()) ? got_q[b*9 + i] : 8'h00};
        return v;
    endfunction

    task automatic send(input logic [7:0] pix, input bit sof, input bit noisy);
        int guard = 0;
        bus.DI  = pix;
        bus.DVI = 1'b1;
        bus.SOF = sof;
        while (!bus.RDY) begin
            if (noisy) begin
                bus.DI   = 8'($urandom);
                bus.DVI  = 1'($urandom_range(0, 1));
                bus.SOF  = 1'b0;
                bus.BUSY = ($urandom_range(0, 2) == 0);
            end
            @(negedge clk);
            guard++;
            if (guard > 300) begin
                check("send_timeout", 72'd1, 72'd0);
                break;
            end
        end
        bus.DI  = pix;
        bus.DVI = 1'b1;
        bus.SOF = sof;
        @(negedge clk);
        bus.DVI = 1'b0;
        bus.SOF = 1'b0;
    endtask

    // Raster-order pixels from (0,0) with SOF on the first; value base+16*row+col or random.
    task automatic send_seq(input logic [7:0] base, input int npix, input bit rnd,
                            input bit noisy, input bit gap);
        for (int n = 0; n < npix; n++) begin
            logic [7:0] pix;
            pix = rnd ? 8'($urandom) : 8'(base + 16*(n / WIDTH) + (n % WIDTH));
            if (noisy) bus.BUSY = ($urandom_range(0, 3) == 0);
            send(pix, n == 0, noisy);
            if (gap) @(negedge clk);
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (!(m_rdy && !pending && remaining == 0)) begin
            bus.BUSY = 1'b0;
            @(negedge clk);
            guard++;
            if (guard > 100) begin
                check("drain_timeout", 72'd1, 72'd0);
                break;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        bus.DI   = '0;
        bus.DVI  = 1'b0;
        bus.SOF  = 1'b0;
        bus.BUSY = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_rdy", {71'd0, bus.RDY}, 72'd1);
        check("reset_dso", {71'd0, bus.DSO}, 72'd0);
        check("reset_do",  {64'd0, bus.DO},  72'd0);

        // Gapped frame, BUSY low: bursts only at (2,2) and (2,3).
        got_q.delete();
        send_seq(8'h00, 3*WIDTH, 1'b0, 1'b0, 1'b1);
        drain();
        check("t1_count",  72'(got_q.size()), 72'd18);
        check("t1_burst0", burst_vec(0), 72'h00_01_02_10_11_12_20_21_22);
        check("t1_burst1", burst_vec(1), 72'h01_02_03_11_12_13_21_22_23);

        // Continuous DVI, four rows: row 3 border pixels give nothing, (3,2) burst checked.
        got_q.delete();
        send_seq(8'h00, 4*WIDTH, 1'b0, 1'b0, 1'b0);
        drain();
        check("t2_count",  72'(got_q.size()), 72'd36);
        check("t2_burst2", burst_vec(2), 72'h10_11_12_20_21_22_30_31_32);

        // BUSY high at (2,2), released five cycles later.
        got_q.delete();
        send_seq(8'h00, 2*WIDTH + 2, 1'b0, 1'b0, 1'b0);
        bus.BUSY = 1'b1;
        send(8'h22, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_dso", {71'd0, bus.DSO}, 72'd0);
            check("t3_hold_rdy", {71'd0, bus.RDY}, 72'd0);
            @(negedge clk);
        end
        bus.BUSY = 1'b0;
        @(negedge clk);
        check("t3_start", {71'd0, bus.DSO}, 72'd1);
        drain();
        send(8'h23, 1'b0, 1'b0);
        drain();
        check("t3_burst0", burst_vec(0), 72'h00_01_02_10_11_12_20_21_22);

        // Reset at k=4 of the (2,2) burst, then a fresh frame.
        got_q.delete();
        send_seq(8'h00, 2*WIDTH + 3, 1'b0, 1'b0, 1'b0);
        guard = 0;
        while (!bus.DSO && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("t4_burst_seen", {71'd0, bus.DSO}, 72'd1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4_partial", 72'(got_q.size()), 72'd5);
        check("t4_rst_dso", {71'd0, bus.DSO}, 72'd0);
        check("t4_rst_rdy", {71'd0, bus.RDY}, 72'd1);
        got_q.delete();
        send_seq(8'h80, 3*WIDTH, 1'b0, 1'b0, 1'b1);
        drain();
        check("t4_count",  72'(got_q.size()), 72'd18);
        check("t4_burst0", burst_vec(0), 72'h80_81_82_90_91_92_a0_a1_a2);

        // Frame A cut by SOF at its (2,1); frame B must wait for its own row 2.
        got_q.delete();
        send_seq(8'h00, 2*WIDTH + 1, 1'b0, 1'b0, 1'b0);
        send_seq(8'h40, 3*WIDTH, 1'b0, 1'b0, 1'b0);
        drain();
        check("t5_count",  72'(got_q.size()), 72'd18);
        check("t5_burst0", burst_vec(0), 72'h40_41_42_50_51_52_60_61_62);

        // Random pixels, random BUSY, DVI/DI noise while stalled.
        got_q.delete();
        for (int f = 0; f < 3; f++) send_seq(8'h00, 4*WIDTH, 1'b1, 1'b1, 1'b0);
        drain();
        check("t6_count", 72'(got_q.size()), 72'd108);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
